data_lsu: RTL

Load/store unit sitting directly downstream of decode/execute: consumes the memory fields of control_t (data_req, data_wr, data_byte, zero_extnd) plus the ALU-computed address and rs2 data. Drives a single-outstanding valid/ready request bus to data memory, aligns store data to byte lanes, and extracts and extends load data. Returns load data to the register-file writeback mux (rf_wr_data_sel = MEM) and stalls the pipeline while a transaction is in flight.

---
 rtl/data_lsu_pkg.sv | 32 +++
 rtl/lsu_load_align.sv | 37 +++
 rtl/data_lsu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/data_lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// alignment fault rule.
package data_lsu_pkg;

    typedef enum logic [1:0] {
        BYTE        = 2'd0,
        HALF_WORD   = 2'd1,
        WORD        = 2'd2,
        DOUBLE_WORD = 2'd3
    } mem_access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // DOUBLE_WORD has no legal encoding on a 32-bit data bus, so it always faults.
    function automatic logic is_misaligned(input mem_access_size_t size,
                                           input logic [1:0]       off);
        logic mis;
        case (size)
            BYTE:      mis = 1'b0;
            HALF_WORD: mis = off[0];
            WORD:      mis = |off;
            default:   mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data aligner: moves the addressed byte/half down to bit 0 and
// sign- or zero-extends it to the register width.
module lsu_load_align
    import data_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]  raw,
    input  logic [1:0]       off,
    input  mem_access_size_t size,
    input  logic             zero_extnd,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] shifted;
    logic            fill;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        shifted = raw >> {off, 3'b000};
        fill    = 1'b0;
        data    = raw;
        case (size)
            BYTE: begin
                fill = ~zero_extnd & shifted[7];
                data = {{(XLEN-8){fill}}, shifted[7:0]};
            end
            HALF_WORD: begin
                fill = ~zero_extnd & shifted[15];
                data = {{(XLEN-16){fill}}, shifted[15:0]};
            end
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// Single-outstanding load/store unit: issues one valid/ready memory request
// per instruction, aligns store lanes and returns extended load data.
module data_lsu
    import data_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_byte,
    input  logic              zero_extnd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wr_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [3:0]        mem_byte_en,
    output logic [XLEN-1:0]   mem_wr_data,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              lsu_stall,
    output logic              ld_valid,
    output logic [XLEN-1:0]   ld_data,
    output logic              misaligned
);

    lsu_state_t       state;
    logic [1:0]       off_q;
    mem_access_size_t size_q;
    logic             zext_q;

    mem_access_size_t size_in;
    logic [3:0]       be_next;
    logic [XLEN-1:0]  wd_next;
    logic             mis_next;
    logic [XLEN-1:0]  align_data;

    assign size_in  = mem_access_size_t'(data_byte);
    assign mis_next = is_misaligned(size_in, addr[1:0]);

    // Reads drive the same lane enables as writes of the same size.
    always_comb begin
        be_next = 4'b0000;
        wd_next = wr_data;
        case (size_in)
            BYTE: begin
                be_next = 4'b0001 << addr[1:0];
                wd_next = {4{wr_data[7:0]}};
            end
            HALF_WORD: begin
                be_next = 4'b0011 << addr[1:0];
                wd_next = {2{wr_data[15:0]}};
            end
            WORD:    be_next = 4'b1111;
            default: be_next = 4'b0000;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .raw        (mem_rsp_data),
        .off        (off_q),
        .size       (size_q),
        .zero_extnd (zext_q),
        .data       (align_data)
    );

    assign lsu_stall = ((state == IDLE) && data_req) || (state == REQ) || (state == RSP);

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            off_q         <= 2'b00;
            size_q        <= BYTE;
            zext_q        <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wr        <= 1'b0;
            mem_byte_en   <= 4'b0000;
            mem_wr_data   <= '0;
            ld_valid      <= 1'b0;
            ld_data       <= '0;
            misaligned    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req) begin
                        off_q  <= addr[1:0];
                        size_q <= size_in;
                        zext_q <= zero_extnd;
                        if (mis_next) begin
                            // Faulting access completes without touching the bus.
                            state      <= DONE;
                            misaligned <= 1'b1;
                            ld_valid   <= ~data_wr;
                            if (!data_wr) ld_data <= '0;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wr        <= data_wr;
                            mem_byte_en   <= be_next;
                            mem_wr_data   <= wd_next;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid) begin
                        state <= DONE;
                        if (!mem_wr) begin
                            ld_valid <= 1'b1;
                            ld_data  <= align_data;
                        end
                    end
                end
                DONE: begin
                    ld_valid   <= 1'b0;
                    misaligned <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
